trig_coincid_window: RTL and testbench

- Parametrised successor to the fixed 3-channel trigger selector.
- Synchronises NCH active-low HARDROC trigger lines plus one external trigger and stretches each channel edge into a programmable coincidence window.
- Forms OR, AND or k-of-N majority coincidence, or passes the external trigger, and emits a single-cycle TrigOut followed by a programmable hold-off.
- Sits between the ASIC trigger pads and the acquisition/S-curve counting logic.

---
 rtl/trig_coincid_pkg.sv | 27 ++
 rtl/trig_chan_window.sv | 60 ++++++
 rtl/trig_coincid_window.sv | 164 ++++++++++++++++
 tb/tb_trig_coincid_window.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_coincid_pkg.sv
// Shared mode encodings, FSM state type and popcount helper for trig_coincid_window.
package trig_coincid_pkg;

    typedef enum logic [1:0] {
        MODE_OR  = 2'b00,
        MODE_AND = 2'b01,
        MODE_MAJ = 2'b10,
        MODE_EXT = 2'b11
    } modeT;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } stateT;

    localparam int unsigned MAX_CH = 16;

    function automatic logic [4:0] popcount(input logic [MAX_CH-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/trig_chan_window.sv
// One trigger channel: 2-flop synchroniser, delay flop for rising-edge detect and a
// retriggerable coincidence window that stays high for windowLen+1 cycles.
module trig_chan_window #(
    parameter int unsigned WIN_W = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             sigIn,
    input  logic             load,
    input  logic             clear,
    input  logic [WIN_W-1:0] windowLen,
    output logic             level,
    output logic             edgeDet,
    output logic             flag
);

    logic             s1, s2, s3;
    logic [WIN_W-1:0] winCntQ, winCntD;
    logic             flagQ, flagD;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            winCntQ <= '0;
            flagQ   <= 1'b0;
        end else begin
            s1      <= sigIn;
            s2      <= s1;
            s3      <= s2;
            winCntQ <= winCntD;
            flagQ   <= flagD;
        end
    end

    assign edgeDet = s2 & ~s3;
    assign level   = s2;
    assign flag    = flagQ;

    // Clear beats load so an edge landing on the fire cycle is dropped with the rest.
    always_comb begin
        winCntD = winCntQ;
        flagD   = flagQ;
        if (clear) begin
            winCntD = '0;
            flagD   = 1'b0;
        end else if (load) begin
            winCntD = windowLen;
            flagD   = 1'b1;
        end else if (flagQ) begin
            if (winCntQ != '0) begin
                winCntD = winCntQ - WIN_W'(1);
            end else begin
                flagD = 1'b0;
            end
        end
    end

endmodule

// File: rtl/trig_coincid_window.sv
// Coincidence trigger: OR / AND / k-of-N / external selection with hold-off FSM.
// Optional macro TRIG_VETO_COUNT_EN adds VetoCount (edges seen while in hold-off).
module trig_coincid_window
    import trig_coincid_pkg::*;
#(
    parameter  int unsigned NCH    = 3,
    parameter  int unsigned WIN_W  = 4,
    parameter  int unsigned HOLD_W = 8,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned MAJ_W  = $clog2(NCH + 1)
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [NCH-1:0]    TrigInB,
    input  logic              ExtTrig,
    input  logic              Enable,
    input  logic [1:0]        ModeSel,
    input  logic [NCH-1:0]    ChanMask,
    input  logic [MAJ_W-1:0]  Majority,
    input  logic [WIN_W-1:0]  WindowLen,
    input  logic [HOLD_W-1:0] HoldOff,
    input  logic              ClearCount,
    output logic              TrigOut,
    output logic              TrigAnd,
    output logic              TrigOr,
    output logic              ExtTrigSync,
    output logic              Busy,
`ifdef TRIG_VETO_COUNT_EN
    output logic [CNT_W-1:0]  VetoCount,
`endif
    output logic [CNT_W-1:0]  TrigCount
);

    stateT             stateQ, stateD;
    logic [HOLD_W-1:0] holdCntQ, holdCntD;
    logic [CNT_W-1:0]  trigCountQ, trigCountD;
    logic [NCH-1:0]    chanEdge, chanLoad, flags, maskedFlags, chanLevelUnused;
    logic              extEdge, extFlagUnused;
    logic              winClear, fire, cond, andCond;
    logic [4:0]        nSet, majK;

    for (genvar i = 0; i < NCH; i++) begin : gChan
        trig_chan_window #(.WIN_W(WIN_W)) uChan (
            .Clk      (Clk),
            .reset    (reset),
            .sigIn    (~TrigInB[i]),
            .load     (chanLoad[i]),
            .clear    (winClear),
            .windowLen(WindowLen),
            .level    (chanLevelUnused[i]),
            .edgeDet  (chanEdge[i]),
            .flag     (flags[i])
        );
    end

    // External trigger only needs the synchroniser and edge detect.
    trig_chan_window #(.WIN_W(1)) uExt (
        .Clk      (Clk),
        .reset    (reset),
        .sigIn    (ExtTrig),
        .load     (1'b0),
        .clear    (1'b1),
        .windowLen(1'b0),
        .level    (ExtTrigSync),
        .edgeDet  (extEdge),
        .flag     (extFlagUnused)
    );

    assign chanLoad    = chanEdge & ChanMask & {NCH{Enable && (stateQ == ST_IDLE)}};
    assign winClear    = !Enable || fire;
    assign maskedFlags = flags & ChanMask;
    assign nSet        = popcount(MAX_CH'(maskedFlags));
    assign majK        = (Majority == '0) ? 5'd1 : 5'(Majority);
    assign andCond     = (ChanMask != '0) && ((flags | ~ChanMask) == '1);

    always_comb begin
        cond = 1'b0;
        case (modeT'(ModeSel))
            MODE_OR:  cond = |maskedFlags;
            MODE_AND: cond = andCond;
            MODE_MAJ: cond = (nSet >= majK);
            MODE_EXT: cond = extEdge;
            default:  cond = 1'b0;
        endcase
    end

    always_comb begin
        stateD     = stateQ;
        holdCntD   = holdCntQ;
        trigCountD = trigCountQ;
        fire       = 1'b0;
        case (stateQ)
            ST_IDLE: begin
                if (Enable && cond) begin
                    fire     = 1'b1;
                    holdCntD = HoldOff;
                    stateD   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (holdCntQ == '0) begin
                    stateD = ST_IDLE;
                end else begin
                    holdCntD = holdCntQ - HOLD_W'(1);
                end
            end
            default: stateD = ST_IDLE;
        endcase
        if (ClearCount) begin
            trigCountD = '0;
        end else if (fire && (trigCountQ != '1)) begin
            trigCountD = trigCountQ + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            stateQ     <= ST_IDLE;
            holdCntQ   <= '0;
            trigCountQ <= '0;
            TrigOut    <= 1'b0;
            TrigAnd    <= 1'b0;
            TrigOr     <= 1'b0;
        end else begin
            stateQ     <= stateD;
            holdCntQ   <= holdCntD;
            trigCountQ <= trigCountD;
            TrigOut    <= fire;
            TrigAnd    <= andCond;
            TrigOr     <= |maskedFlags;
        end
    end

    assign Busy      = (stateQ == ST_HOLD);
    assign TrigCount = trigCountQ;

`ifdef TRIG_VETO_COUNT_EN
    logic [CNT_W-1:0] vetoCountQ, vetoCountD;
    logic             vetoEv;

    assign vetoEv = (stateQ == ST_HOLD) &&
                    ((modeT'(ModeSel) == MODE_EXT) ? extEdge : |(chanEdge & ChanMask));

    always_comb begin
        vetoCountD = vetoCountQ;
        if (ClearCount) begin
            vetoCountD = '0;
        end else if (vetoEv && (vetoCountQ != '1)) begin
            vetoCountD = vetoCountQ + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            vetoCountQ <= '0;
        end else begin
            vetoCountQ <= vetoCountD;
        end
    end

    assign VetoCount = vetoCountQ;
`endif

endmodule

// File: tb/tb_trig_coincid_window.sv
// Self-checking bench: table of coincidence scenarios plus hand-written multi-cycle sequences.
module tb_trig_coincid_window;
    import trig_coincid_pkg::*;

    logic       Clk = 1'b0;
    logic       reset;
    logic [2:0] TrigInB;
    logic       ExtTrig, Enable, ClearCount;
    logic [1:0] ModeSel;
    logic [2:0] ChanMask;
    logic [1:0] Majority;
    logic [3:0] WindowLen;
    logic [7:0] HoldOff;
    logic       TrigOut, TrigAnd, TrigOr, ExtTrigSync, Busy;
    logic [3:0] TrigCount;
`ifdef TRIG_VETO_COUNT_EN
    logic [3:0] VetoCount;
`endif

    trig_coincid_window #(.NCH(3), .WIN_W(4), .HOLD_W(8), .CNT_W(4)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .TrigInB    (TrigInB),
        .ExtTrig    (ExtTrig),
        .Enable     (Enable),
        .ModeSel    (ModeSel),
        .ChanMask   (ChanMask),
        .Majority   (Majority),
        .WindowLen  (WindowLen),
        .HoldOff    (HoldOff),
        .ClearCount (ClearCount),
        .TrigOut    (TrigOut),
        .TrigAnd    (TrigAnd),
        .TrigOr     (TrigOr),
        .ExtTrigSync(ExtTrigSync),
        .Busy       (Busy),
`ifdef TRIG_VETO_COUNT_EN
        .VetoCount  (VetoCount),
`endif
        .TrigCount  (TrigCount)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int expQ[$];
    int expCount = 0;
    int expVeto = 0;
    int monExp;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [2:0] mask;
        logic [1:0] maj;
        logic [3:0] win;
        logic [7:0] hold;
        int         off0, off1, off2, offE;
        int         expRel;
    } vecT;

    vecT vecs[12];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int satInc(input int c);
        return (c >= 15) ? 15 : c + 1;
    endfunction

    // Scoreboard: every TrigOut must match the oldest expected fire cycle.
    always @(negedge Clk) begin
        if (!reset && TrigOut === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_trigout: got pulse at cycle %0d, expected none", cyc);
            end else begin
                monExp = expQ.pop_front();
                if (monExp != cyc) begin
                    errors++;
                    $display("FAIL trigout_time: got cycle %0d, expected %0d", cyc, monExp);
                end
            end
        end
    end

    task automatic drain(input string name);
        chk({name, "_missed"}, expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic run_vec(input int idx);
        vecT v;
        int  base;
        int  offs[4];
        v = vecs[idx];
        offs[0] = v.off0; offs[1] = v.off1; offs[2] = v.off2; offs[3] = v.offE;
        Enable = v.en; ModeSel = v.mode; ChanMask = v.mask; Majority = v.maj;
        WindowLen = v.win; HoldOff = v.hold;
        tick();
        base = cyc;
        if (v.expRel >= 0) begin
            expQ.push_back(base + v.expRel);
            expCount = satInc(expCount);
        end
        for (int t = 0; t < 25; t++) begin
            for (int c = 0; c < 3; c++) if (offs[c] == t) TrigInB[c] = 1'b0;
            if (offs[3] == t) ExtTrig = 1'b1;
            tick();
        end
        TrigInB = 3'b111;
        ExtTrig = 1'b0;
        repeat (20) tick();
        drain($sformatf("vec%0d", idx));
        chk($sformatf("vec%0d_count", idx), int'(TrigCount), expCount);
    endtask

    initial begin
        int base, busyCnt, lastF, e;

        //           en    mode      mask    maj  win  hold  off0 off1 off2 offE exp
        vecs[0]  = '{1'b1, MODE_OR,  3'b111, 2'd0, 4'd0, 8'd5, -1,  0,  -1, -1,  4};
        vecs[1]  = '{1'b1, MODE_AND, 3'b111, 2'd0, 4'd3, 8'd2,  0,  3,   3, -1,  7};
        vecs[2]  = '{1'b1, MODE_AND, 3'b111, 2'd0, 4'd3, 8'd2,  0,  3,   4, -1, -1};
        vecs[3]  = '{1'b1, MODE_MAJ, 3'b101, 2'd2, 4'd0, 8'd2, -1,  0,   0, -1, -1};
        vecs[4]  = '{1'b1, MODE_MAJ, 3'b101, 2'd2, 4'd0, 8'd2,  0, -1,   0, -1,  4};
        vecs[5]  = '{1'b1, MODE_EXT, 3'b111, 2'd0, 4'd0, 8'd2,  0, -1,  -1,  5,  8};
        vecs[6]  = '{1'b1, MODE_OR,  3'b000, 2'd0, 4'd2, 8'd2,  0,  0,   0, -1, -1};
        vecs[7]  = '{1'b1, MODE_MAJ, 3'b111, 2'd0, 4'd0, 8'd2, -1, -1,   2, -1,  6};
        vecs[8]  = '{1'b1, MODE_MAJ, 3'b011, 2'd3, 4'd0, 8'd2,  0,  0,  -1, -1, -1};
        vecs[9]  = '{1'b0, MODE_OR,  3'b111, 2'd0, 4'd2, 8'd2,  0,  1,   2,  3, -1};
        vecs[10] = '{1'b1, MODE_AND, 3'b010, 2'd0, 4'd0, 8'd2, -1,  1,  -1, -1,  5};
        vecs[11] = '{1'b1, MODE_OR,  3'b111, 2'd0, 4'd2, 8'd0,  0, -1,   1, -1,  4};

        reset = 1'b1; TrigInB = 3'b111; ExtTrig = 1'b0; Enable = 1'b0; ClearCount = 1'b0;
        ModeSel = MODE_OR; ChanMask = 3'b111; Majority = 2'd0; WindowLen = 4'd0; HoldOff = 8'd0;
        repeat (3) tick();
        chk("reset_flags", int'({TrigOut, TrigAnd, TrigOr, ExtTrigSync, Busy}), 0);
        chk("reset_count", int'(TrigCount), 0);
        reset = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 12; i++) run_vec(i);

        // Single OR edge: TrigOr alongside TrigOut, hold-off of HoldOff+1 cycles.
        Enable = 1'b1; ModeSel = MODE_OR; ChanMask = 3'b111; WindowLen = 4'd0; HoldOff = 8'd5;
        tick();
        base = cyc; busyCnt = 0;
        expQ.push_back(base + 4);
        expCount = satInc(expCount);
        for (int t = 0; t < 20; t++) begin
            if (t == 0) TrigInB[1] = 1'b0;
            tick();
            busyCnt += int'(Busy);
            if (cyc == base + 4) begin
                chk("or_level", int'({TrigOr, TrigAnd}), 2);
                chk("busy_at_fire", int'(Busy), 1);
            end
        end
        TrigInB = 3'b111;
        repeat (5) tick();
        chk("busy_len", busyCnt, 6);
        drain("single_or");
        chk("single_or_count", int'(TrigCount), expCount);

        // Edges every 3 cycles against HoldOff=10: fires only once the hold-off expires.
        HoldOff = 8'd10;
        tick();
        base = cyc; lastF = -1000;
        for (int p = 0; p < 12; p++) begin
            e = base + 3 * p + 2;
            if (e >= lastF + 11) begin
                lastF = base + 3 * p + 4;
                expQ.push_back(lastF);
                expCount = satInc(expCount);
            end else if (e >= lastF) begin
                expVeto++;
            end
        end
        for (int t = 0; t < 45; t++) begin
            TrigInB[0] = ((t % 3 == 0) && (t < 36)) ? 1'b0 : 1'b1;
            tick();
        end
        TrigInB = 3'b111;
        repeat (15) tick();
        drain("holdoff_train");
        chk("holdoff_count", int'(TrigCount), expCount);
`ifdef TRIG_VETO_COUNT_EN
        chk("veto_count", int'(VetoCount), expVeto);
`endif

        // 20 external triggers with HoldOff=0 saturate the 4-bit counter.
        ModeSel = MODE_EXT; HoldOff = 8'd0;
        tick();
        base = cyc;
        for (int p = 0; p < 20; p++) begin
            expQ.push_back(base + 3 * p + 3);
            expCount = satInc(expCount);
        end
        for (int t = 0; t < 65; t++) begin
            ExtTrig = ((t % 3 == 0) && (t < 60)) ? 1'b1 : 1'b0;
            tick();
        end
        drain("ext_train");
        chk("saturate", int'(TrigCount), expCount);

        // ClearCount on the same edge as a fire wins over the increment.
        base = cyc;
        expQ.push_back(base + 3);
        for (int t = 0; t < 10; t++) begin
            ExtTrig = (t == 0);
            ClearCount = (t == 2);
            tick();
        end
        ClearCount = 1'b0;
        expCount = 0;
        drain("clear_fire");
        chk("clear_count", int'(TrigCount), 0);
`ifdef TRIG_VETO_COUNT_EN
        chk("clear_veto", int'(VetoCount), 0);
`endif

        // Reset during hold-off aborts everything; the next edge fires normally.
        ModeSel = MODE_OR; WindowLen = 4'd3; HoldOff = 8'd10;
        tick();
        base = cyc;
        expQ.push_back(base + 4);
        for (int t = 0; t < 8; t++) begin
            if (t == 0) TrigInB[1] = 1'b0;
            if (t == 6) TrigInB = 3'b000;
            tick();
        end
        chk("busy_before_reset", int'(Busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("reset_mid_flags", int'({TrigOut, TrigAnd, TrigOr, ExtTrigSync, Busy}), 0);
        chk("reset_mid_count", int'(TrigCount), 0);
`ifdef TRIG_VETO_COUNT_EN
        chk("reset_mid_veto", int'(VetoCount), 0);
`endif
        drain("pre_reset");
        TrigInB = 3'b111;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        base = cyc;
        expQ.push_back(base + 4);
        expCount = 1;
        for (int t = 0; t < 20; t++) begin
            if (t == 0) TrigInB[2] = 1'b0;
            tick();
        end
        TrigInB = 3'b111;
        repeat (5) tick();
        drain("post_reset");
        chk("post_reset_count", int'(TrigCount), expCount);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
